// File: rtl/vend_sequencer_if.sv
// rtl/vend_sequencer_if.sv - key input and display/actuator outputs of the vending sequencer
interface vend_sequencer_if;
    logic       key_valid;
    logic [2:0] key_code;
    logic [3:0] credit;
    logic [2:0] candy_count;
    logic [2:0] can_buy;
    logic [2:0] dispense;
    logic       change_pulse;
    logic       coin_reject;
    logic       busy;

    modport master (
        output key_valid, key_code,
        input  credit, candy_count, can_buy, dispense, change_pulse, coin_reject, busy
    );

    modport slave (
        input  key_valid, key_code,
        output credit, candy_count, can_buy, dispense, change_pulse, coin_reject, busy
    );
endinterface

// File: rtl/vend_sequencer.sv
// rtl/vend_sequencer.sv - coin/select/cancel sequencer with timed dispense and unit change payback
module vend_sequencer #(
    parameter int DISP_CYC    = 50,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic            clk,
    input  logic            reset,
    vend_sequencer_if.slave bus
);
    localparam int DW = (DISP_CYC > 1) ? $clog2(DISP_CYC) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [DW-1:0] DISP_LAST = DW'(DISP_CYC - 1);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYC);

    typedef enum logic [1:0] {IDLE, CREDIT, DISPENSE, CHANGE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    credit_q, credit_d;
    logic [2:0]    count_q, count_d;
    logic [2:0]    disp_q, disp_d;
    logic          pulse_q, pulse_d;
    logic          reject_q, reject_d;
    logic          busy_q, busy_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;

    logic       is_coin, is_sel, is_cancel, key_live;
    logic [3:0] coin_val, price;
    logic [2:0] item;
    logic [4:0] sum;

    always_comb begin
        coin_val = 4'd0;
        price    = 4'd0;
        item     = 3'b000;
        case (bus.key_code)
            3'd1:    coin_val = 4'd1;
            3'd2:    coin_val = 4'd2;
            3'd3:    coin_val = 4'd5;
            3'd4:    begin price = 4'd3; item = 3'b001; end
            3'd5:    begin price = 4'd5; item = 3'b010; end
            3'd6:    begin price = 4'd7; item = 3'b100; end
            default: ;
        endcase
    end

    assign key_live  = bus.key_valid && (bus.key_code != 3'd0);
    assign is_coin   = key_live && (bus.key_code <= 3'd3);
    assign is_sel    = key_live && (bus.key_code >= 3'd4) && (bus.key_code <= 3'd6);
    assign is_cancel = key_live && (bus.key_code == 3'd7);
    assign sum       = {1'b0, credit_q} + {1'b0, coin_val};

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        count_d  = count_q;
        disp_d   = disp_q;
        pulse_d  = pulse_q;
        reject_d = 1'b0;
        busy_d   = busy_q;
        dcnt_d   = dcnt_q;
        tcnt_d   = tcnt_q;
        case (state_q)
            IDLE: begin
                if (is_coin) begin
                    if (sum <= 5'd15) begin
                        credit_d = sum[3:0];
                        state_d  = CREDIT;
                        tcnt_d   = '0;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            CREDIT: begin
                // Any real key restarts the idle timer, and a key always beats a timeout on the same edge.
                if (key_live) begin
                    tcnt_d = '0;
                    if (is_coin) begin
                        if (sum <= 5'd15) credit_d = sum[3:0];
                        else              reject_d = 1'b1;
                    end else if (is_sel && (credit_q >= price)) begin
                        credit_d = credit_q - price;
                        disp_d   = item;
                        busy_d   = 1'b1;
                        dcnt_d   = '0;
                        state_d  = DISPENSE;
                    end else if (is_cancel) begin
                        pulse_d = 1'b1;
                        busy_d  = 1'b1;
                        state_d = CHANGE;
                    end
                end else if (tcnt_q == TMO_LIMIT) begin
                    pulse_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = CHANGE;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            DISPENSE: begin
                if (dcnt_q == DISP_LAST) begin
                    disp_d  = 3'b000;
                    count_d = count_q + 1'b1;
                    if (credit_q != 4'd0) begin
                        pulse_d = 1'b1;
                        state_d = CHANGE;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            CHANGE: begin
                // High cycle pays one unit; the following low cycle decides whether more remain.
                if (pulse_q) begin
                    pulse_d  = 1'b0;
                    credit_d = credit_q - 4'd1;
                end else if (credit_q == 4'd0) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    pulse_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            credit_q <= 4'd0;
            count_q  <= 3'd0;
            disp_q   <= 3'b000;
            pulse_q  <= 1'b0;
            reject_q <= 1'b0;
            busy_q   <= 1'b0;
            dcnt_q   <= '0;
            tcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            count_q  <= count_d;
            disp_q   <= disp_d;
            pulse_q  <= pulse_d;
            reject_q <= reject_d;
            busy_q   <= busy_d;
            dcnt_q   <= dcnt_d;
            tcnt_q   <= tcnt_d;
        end
    end

    assign bus.credit       = credit_q;
    assign bus.candy_count  = count_q;
    assign bus.dispense     = disp_q;
    assign bus.change_pulse = pulse_q;
    assign bus.coin_reject  = reject_q;
    assign bus.busy         = busy_q;
    assign bus.can_buy      = busy_q ? 3'b000 :
                              {credit_q >= 4'd7, credit_q >= 4'd5, credit_q >= 4'd3};
endmodule
